piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter that produces the one-bit stream consumed by the team's serial-in shift registers.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out one bit per enabled clock, with a frame marker and a completion pulse.
- Sits between a parallel data source and any serial-in receiver in the design.

Parameters:
WIDTH, 4, word length in bits (legal range >= 2).
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
GAP_CYCLES, 0, number of idle clock cycles inserted after each word (0 = back-to-back words allowed).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
d  input  WIDTH  parallel word to transmit.
load_valid  input  1  source has a word on d.
load_ready  output  1  serializer accepts d this cycle.
shift_en  input  1  bit strobe; the current bit is consumed on a clock edge where shift_en=1.
dout  output  1  serial data.
dout_valid  output  1  dout carries a word bit.
frame_start  output  1  high while dout carries the first bit of a word.
done  output  1  one-cycle pulse on the edge that consumes the last bit.
busy  output  1  state != IDLE.

Behaviour:
- Interface (decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE; shift register and bit counter = 0.
  - dout = 0, dout_valid = 0, frame_start = 0, done = 0, busy = 0, load_ready = 1.
  - Reset acts immediately, not on the next edge.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - load_ready = 1, dout = 0, dout_valid = 0.
  - On load_valid & load_ready: capture d, cnt = 0, go to SHIFT.
  - First bit appears on dout the cycle after capture (latency 1).
- SHIFT:
  - dout_valid = 1.
  - dout = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
  - frame_start = (cnt == 0).
  - On an edge with shift_en = 1:
    - Shift the register toward the output end, filling with 0.
    - cnt increments.
  - On an edge with shift_en = 0: dout and cnt hold.
- Last bit (cnt == WIDTH-1 and shift_en = 1):
  - done = 1 for exactly that cycle.
  - If GAP_CYCLES > 0: go to GAP.
  - If GAP_CYCLES = 0 and load_valid = 1: capture the new word, cnt = 0, stay in SHIFT. The stream has no bubble.
  - If GAP_CYCLES = 0 and load_valid = 0: go to IDLE.
- load_ready is combinational:
  - (state == IDLE), or
  - (state == SHIFT && cnt == WIDTH-1 && shift_en && GAP_CYCLES == 0).
  - load_valid in any other cycle is ignored; no word is captured or lost internally.
- GAP:
  - dout = 0, dout_valid = 0, load_ready = 0.
  - A down-counter runs GAP_CYCLES clocks, independent of shift_en, then returns to IDLE.
- Widths:
  - cnt is max(1, $clog2(WIDTH)) bits and never exceeds WIDTH-1.
  - The gap counter is max(1, $clog2(GAP_CYCLES+1)) bits.
- Changes on d while not being captured have no effect.
- Reset mid-word: the current word is discarded and the block behaves exactly as after power-on reset.

Decomposition:
- Shared package piso_pkg holds:
  - state enum (IDLE, SHIFT, GAP);
  - localparam helpers for the counter widths.
- No sub-module is required. The gap counter may be a generic down_counter instance if one already exists; otherwise it is inline.

Test Plan:
Each scenario uses WIDTH=4 and starts from reset released.
- Basic MSB-first (MSB_FIRST=1, GAP_CYCLES=0): d=4'b1010, load_valid one cycle, shift_en=1 -> dout 1,0,1,0 on cycles 1-4; frame_start only on cycle 1; done on cycle 4; IDLE with dout_valid=0 on cycle 5.
- LSB-first (MSB_FIRST=0): d=4'b1011 -> dout 1,1,0,1; done on the 4th bit.
- Back-to-back: words 1010 then 0110, load_valid held high -> 8 contiguous bits 1,0,1,0,0,1,1,0; dout_valid never drops; frame_start on bits 1 and 5; done on bits 4 and 8.
- Stall: d=4'b1100, shift_en pattern 1,0,0,1,1,1 -> dout 1 held for the bit-2 position through the low strobes; order is still 1,1,0,0; done only on the final enabled edge.
- Gap (GAP_CYCLES=2): two words with load_valid held high -> exactly 2 cycles of dout_valid=0 and load_ready=0 between words.
- Reset and ignored load:
  - Assert rst asynchronously after 2 bits of 4'b1111 -> dout=0, dout_valid=0, load_ready=1 before the next clock edge; the next word transmits cleanly.
  - load_valid asserted mid-word with d=4'b0001 -> ignored; the current word is unchanged.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and width helpers for the parallel-in, serial-out transmitter.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Bit counter width: max(1, clog2(width)).
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

  // Gap down-counter width: max(1, clog2(gap + 1)).
  function automatic int gap_width(input int gap);
    int w;
    w = $clog2(gap + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Shifts a WIDTH-bit word out one bit per enabled clock, with frame marker,
// last-bit pulse and an optional idle gap between words.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam int GW = gap_width(GAP_CYCLES);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             out_bit;
  logic             last_bit;

  // The output end of the register depends on bit order; the vacated end fills with 0.
  generate
    if (MSB_FIRST) begin : g_msb
      assign out_bit       = shreg_q[WIDTH-1];
      assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign out_bit       = shreg_q[0];
      assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    last_bit   = (state_q == SHIFT) && (cnt_q == LAST_IDX) && shift_en;
    load_ready = (state_q == IDLE) || (last_bit && (GAP_CYCLES == 0));

    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;

    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          shreg_d = d;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          shreg_d = shreg_shifted;
          cnt_d   = cnt_q + 1'b1;
          if (last_bit) begin
            cnt_d = '0;
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end else if (load_valid) begin
              // Seamless hand-over: next word starts on the very next cycle.
              shreg_d = d;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  assign dout_valid  = (state_q == SHIFT);
  assign dout        = dout_valid & out_bit;
  assign frame_start = dout_valid && (cnt_q == '0);
  assign done        = last_bit;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: three serializer variants driven from shared stimulus,
// checked cycle by cycle against a bit-stream model built from the words sent.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic       shift_en;
  logic [3:0] d;
  logic [2:0] lr_w, dout_w, dv_w, fs_w, done_w, busy_w;

  int checks = 0;
  int errors = 0;

  logic [3:0] word_tab [8];
  bit         en_pat [8];
  int         en_len = 0;
  int         gap_idle_cycles;

  always #5 clk = ~clk;

  // 0: MSB first, no gap; 1: LSB first, no gap; 2: MSB first, 2-cycle gap.
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_msb (
    .clk(clk), .rst(rst), .d(d), .load_valid(load_valid), .load_ready(lr_w[0]),
    .shift_en(shift_en), .dout(dout_w[0]), .dout_valid(dv_w[0]),
    .frame_start(fs_w[0]), .done(done_w[0]), .busy(busy_w[0]));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_lsb (
    .clk(clk), .rst(rst), .d(d), .load_valid(load_valid), .load_ready(lr_w[1]),
    .shift_en(shift_en), .dout(dout_w[1]), .dout_valid(dv_w[1]),
    .frame_start(fs_w[1]), .done(done_w[1]), .busy(busy_w[1]));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_gap (
    .clk(clk), .rst(rst), .d(d), .load_valid(load_valid), .load_ready(lr_w[2]),
    .shift_en(shift_en), .dout(dout_w[2]), .dout_valid(dv_w[2]),
    .frame_start(fs_w[2]), .done(done_w[2]), .busy(busy_w[2]));

  // mode 0: shift_en always 1; 1: random; 2: en_pat after first capture.
  // ign: present junk loads (d=0001) whenever the serializer must refuse them.
  task automatic run(input int inst, input int n, input int mode, input bit ign, input bit do_reset);
    int  g, accepted, consumed, gap_left, pc;
    bit  msb, en, in_flight, exp_lr, last, lv, quiet, finished;
    bit  exp_bits[$];
    bit  exp_dout;
    g = (inst == 2) ? 2 : 0;
    msb = (inst != 1);
    accepted = 0; consumed = 0; gap_left = 0; pc = 0;
    quiet = 1'b0; finished = 1'b0; gap_idle_cycles = 0;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 4; i++)
        exp_bits.push_back(msb ? word_tab[k][3-i] : word_tab[k][i]);
    if (do_reset) begin
      rst = 1'b1; load_valid = 1'b0; shift_en = 1'b0; d = 4'h0;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      in_flight = consumed < 4 * accepted;
      case (mode)
        0:       en = 1'b1;
        1:       en = ($urandom_range(0, 3) != 0);
        default: en = (accepted == 0) ? 1'b0 : ((pc < en_len) ? en_pat[pc] : 1'b1);
      endcase
      last   = in_flight && en && (consumed % 4 == 3);
      exp_lr = (!in_flight && gap_left == 0) || (g == 0 && last);
      lv     = (accepted < n) ? 1'b1 : (ign && !exp_lr);
      shift_en   = en;
      load_valid = lv;
      d = (accepted < n && exp_lr) ? word_tab[accepted] : (ign ? 4'b0001 : 4'($urandom));
      exp_dout = in_flight ? exp_bits[consumed] : 1'b0;
      @(negedge clk);
      checks += 6;
      if (dv_w[inst] !== in_flight) begin
        errors++; $display("FAIL dout_valid inst=%0d cyc=%0d got=%b exp=%b", inst, cyc, dv_w[inst], in_flight);
      end
      if (dout_w[inst] !== exp_dout) begin
        errors++; $display("FAIL dout inst=%0d cyc=%0d got=%b exp=%b", inst, cyc, dout_w[inst], exp_dout);
      end
      if (fs_w[inst] !== (in_flight && consumed % 4 == 0)) begin
        errors++; $display("FAIL frame_start inst=%0d cyc=%0d got=%b exp=%b", inst, cyc, fs_w[inst], in_flight && consumed % 4 == 0);
      end
      if (done_w[inst] !== last) begin
        errors++; $display("FAIL done inst=%0d cyc=%0d got=%b exp=%b", inst, cyc, done_w[inst], last);
      end
      if (lr_w[inst] !== exp_lr) begin
        errors++; $display("FAIL load_ready inst=%0d cyc=%0d got=%b exp=%b", inst, cyc, lr_w[inst], exp_lr);
      end
      if (busy_w[inst] !== (in_flight || gap_left > 0)) begin
        errors++; $display("FAIL busy inst=%0d cyc=%0d got=%b exp=%b", inst, cyc, busy_w[inst], in_flight || gap_left > 0);
      end
      if (accepted > 0 && accepted < n && !in_flight && !exp_lr) gap_idle_cycles++;
      if (last) $display("inst %0d word %0d sent %b", inst, consumed / 4, word_tab[consumed / 4]);
      if (in_flight && en) begin
        consumed++;
        if (last && g > 0) gap_left = g;
      end else if (gap_left > 0) begin
        gap_left--;
      end
      if (accepted > 0) pc++;
      if (lv && exp_lr) accepted++;
      finished = quiet;
      quiet = (accepted == n) && (consumed == 4 * n) && (gap_left == 0);
      @(posedge clk); #1;
    end
    checks++;
    if (!finished) begin
      errors++; $display("FAIL timeout inst=%0d got=%0d bits exp=%0d bits", inst, consumed, 4 * n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b1; shift_en = 1'b1; d = 4'b1111;
    @(posedge clk); @(posedge clk); @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks += 6;
      if (lr_w[k] !== 1'b1)   begin errors++; $display("FAIL reset_load_ready inst=%0d got=%b exp=1", k, lr_w[k]); end
      if (dout_w[k] !== 1'b0) begin errors++; $display("FAIL reset_dout inst=%0d got=%b exp=0", k, dout_w[k]); end
      if (dv_w[k] !== 1'b0)   begin errors++; $display("FAIL reset_dout_valid inst=%0d got=%b exp=0", k, dv_w[k]); end
      if (fs_w[k] !== 1'b0)   begin errors++; $display("FAIL reset_frame_start inst=%0d got=%b exp=0", k, fs_w[k]); end
      if (done_w[k] !== 1'b0) begin errors++; $display("FAIL reset_done inst=%0d got=%b exp=0", k, done_w[k]); end
      if (busy_w[k] !== 1'b0) begin errors++; $display("FAIL reset_busy inst=%0d got=%b exp=0", k, busy_w[k]); end
    end
    @(posedge clk); #1;
    rst = 1'b0; load_valid = 1'b0;
  endtask

  task automatic test_basic_msb();
    word_tab[0] = 4'b1010;
    run(0, 1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_lsb_first();
    word_tab[0] = 4'b1011;
    run(1, 1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    word_tab[0] = 4'b1010; word_tab[1] = 4'b0110;
    run(0, 2, 0, 1'b0, 1'b1);
    checks++;
    if (gap_idle_cycles != 0) begin
      errors++; $display("FAIL b2b_bubbles got=%0d exp=0", gap_idle_cycles);
    end
    for (int k = 0; k < 6; k++) word_tab[k] = 4'($urandom);
    run(1, 6, 0, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    word_tab[0] = 4'b1100;
    en_pat[0] = 1'b1; en_pat[1] = 1'b0; en_pat[2] = 1'b0;
    en_pat[3] = 1'b1; en_pat[4] = 1'b1; en_pat[5] = 1'b1;
    en_len = 6;
    run(0, 1, 2, 1'b0, 1'b1);
  endtask

  task automatic test_gap();
    word_tab[0] = 4'b1001; word_tab[1] = 4'b0111;
    run(2, 2, 0, 1'b0, 1'b1);
    checks++;
    if (gap_idle_cycles != 2) begin
      errors++; $display("FAIL gap_cycles got=%0d exp=2", gap_idle_cycles);
    end
    for (int k = 0; k < 5; k++) word_tab[k] = 4'($urandom);
    run(2, 5, 1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midword();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    d = 4'b1111; load_valid = 1'b1; shift_en = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0; d = 4'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks += 2;
    if (dout_w[0] !== 1'b1) begin errors++; $display("FAIL midword_dout got=%b exp=1", dout_w[0]); end
    if (dv_w[0] !== 1'b1)   begin errors++; $display("FAIL midword_valid got=%b exp=1", dv_w[0]); end
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (dout_w[0] !== 1'b0) begin errors++; $display("FAIL async_rst_dout got=%b exp=0", dout_w[0]); end
    if (dv_w[0] !== 1'b0)   begin errors++; $display("FAIL async_rst_valid got=%b exp=0", dv_w[0]); end
    if (lr_w[0] !== 1'b1)   begin errors++; $display("FAIL async_rst_load_ready got=%b exp=1", lr_w[0]); end
    if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL async_rst_busy got=%b exp=0", busy_w[0]); end
    @(posedge clk); #1;
    rst = 1'b0; shift_en = 1'b0;
    word_tab[0] = 4'b0110;
    run(0, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_load();
    word_tab[0] = 4'b1010;
    run(0, 1, 0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) word_tab[k] = 4'($urandom);
    run(2, 3, 1, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) word_tab[k] = 4'($urandom);
    run(0, 8, 1, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) word_tab[k] = 4'($urandom);
    run(1, 8, 1, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; shift_en = 1'b0; d = 4'h0;
    test_reset();
    test_basic_msb();
    test_lsb_first();
    test_back_to_back();
    test_stall();
    test_gap();
    test_reset_midword();
    test_ignored_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
